sram_1rw1r_pipelined: RTL and testbench
=======================================

Name: sram_1rw1r_pipelined

Overview:
Parametrised single-clock dual-port (1 read/write + 1 read-only) SRAM behavioural model, successor to the fixed 32x512 macro model. It adds:
- configurable width, depth and write-mask granularity;
- selectable read latency (1 or 2) with output valid strobes;
- a defined same-address collision policy (bypass or old-data), with a collision flag;
- out-of-range address handling.

It sits behind SoC bus adapters wherever a macro-equivalent RAM is needed in simulation and FPGA builds.

Parameters:
DATA_WIDTH, 32, word width in bits.
ADDR_WIDTH, 9, address width.
DEPTH, 512, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
MASK_GRAN, 8, bits per write-mask lane; DATA_WIDTH % MASK_GRAN must be 0 (elaboration $error otherwise).
NUM_WMASKS, DATA_WIDTH/MASK_GRAN, number of mask lanes (derived; do not override).
READ_LATENCY, 1, edges from request sample to dout update; legal values 1 or 2 (elaboration $error otherwise).
BYPASS, 1, 1 = port-1 read colliding with port-0 write returns new merged data; 0 = returns old data.

Ports:
clk  input  1  single clock, all activity on posedge.
rst_n  input  1  asynchronous active-low reset.
csb0  input  1  port 0 active-low select.
web0  input  1  port 0 active-low write enable.
wmask0  input  NUM_WMASKS  per-lane write enable, 1 = write lane.
addr0  input  ADDR_WIDTH  port 0 address.
din0  input  DATA_WIDTH  port 0 write data.
dout0  output  DATA_WIDTH  port 0 read data.
dout0_valid  output  1  one-cycle strobe: dout0 updated this cycle.
csb1  input  1  port 1 active-low select.
addr1  input  ADDR_WIDTH  port 1 address.
dout1  output  DATA_WIDTH  port 1 read data.
dout1_valid  output  1  one-cycle strobe: dout1 updated this cycle.
collision  output  1  one-cycle strobe: same-address write/read sampled on the same edge.
addr_err  output  1  one-cycle strobe: an access sampled with addr >= DEPTH.

Behaviour:
- Reset (async assert, deassertion sampled on clk):
  - dout0, dout1 = 0; dout0_valid, dout1_valid, collision, addr_err = 0.
  - Read pipeline stages are flushed; an in-flight read is dropped and produces no valid.
  - Memory array is not cleared.
- Request sampling: on posedge N, a port is active if its csb = 0.
  - Port 0 writes when web0 = 0, reads when web0 = 1.
  - Port 1 always reads.
- Write: every lane i with wmask0[i] = 1 is committed at edge N; bits [i*MASK_GRAN +: MASK_GRAN] take din0. Other lanes are unchanged. wmask0 = 0 is a legal no-op and still counts for collision.
- Write visibility: a read on either port sampled at edge N+1 or later sees the write.
- Port 0 has no write-through. During a port-0 write, dout0 holds its value and dout0_valid = 0.
- Read latency:
  - A read sampled at edge N updates dout and pulses its valid for exactly one cycle at edge N+READ_LATENCY.
  - Back-to-back reads give one result per cycle with no bubbles.
  - dout holds its last value between reads (never X, never cleared).
- Collision: a port-0 write and a port-1 read sampled on the same edge with addr0 == addr1 < DEPTH.
  - collision pulses at edge N+1, independent of READ_LATENCY.
  - BYPASS = 1: dout1 = merged word (masked lanes from din0, other lanes from old memory).
  - BYPASS = 0: dout1 = pre-write word.
  - The write always commits.
- Port-0 read and port-1 read of the same address: no collision flag; both return the same stored word.
- Out of range (addr >= DEPTH; only reachable when DEPTH < 2**ADDR_WIDTH):
  - A write is discarded.
  - A read still completes on the normal schedule with dout = 0 and valid pulsed.
  - addr_err pulses at edge N+1. If both ports are out of range on one edge, a single pulse is produced.
- Simultaneous events: both ports active on every edge must be sustained indefinitely.
- Reset asserted on the same edge as a write: reset has priority for outputs only. Whether the write commits is unspecified; benches must not check it.
- Uninitialised words read as X in simulation; benches must write before reading.

Test Plan:
1. Default params. Write addr0 = 5, din0 = 0xDEADBEEF, wmask0 = 4'hF. Port-1 read addr 5 on the next edge -> dout1 = 0xDEADBEEF with dout1_valid one edge after that read sample; no collision.
2. Partial mask. Preload addr 7 = 0x11223344, then write din0 = 0xAABBCCDD, wmask0 = 4'b0101. Port-0 read -> dout0 = 0x11BB33DD.
3. Collision, BYPASS = 1. Preload addr 9 = 0x00000000, then write 0xFFFFFFFF with wmask0 = 4'b0011 while port 1 reads addr 9 on the same edge -> dout1 = 0x0000FFFF, collision = 1 for one cycle. Rerun with BYPASS = 0 -> dout1 = 0x00000000, collision = 1.
4. READ_LATENCY = 2, streaming. Port 1 reads addrs 0..3 on consecutive edges (preloaded 0xA0..0xA3) -> dout1 = 0xA0, 0xA1, 0xA2, 0xA3 on edges N+2..N+5; dout1_valid high 4 consecutive cycles.
5. DEPTH = 300, ADDR_WIDTH = 9. Write addr 400 with din0 = 0x12345678, then read addr 400 -> dout0 = 0, dout0_valid = 1, addr_err pulses on both accesses. A read of addr 299 returns its prior contents (unchanged).
6. Reset mid-read, READ_LATENCY = 2. Sample a port-1 read, then assert rst_n = 0 before edge N+2 -> dout1 = 0, dout1_valid never pulses. After release, a new read returns correct data; memory contents survive reset.

Source files
------------

// File: rtl/sram_1rw1r_pipelined_if.sv
// sram_1rw1r_pipelined_if: request/response bundle between a bus adapter (master) and the 1RW+1R SRAM model (slave).
interface sram_1rw1r_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int MASK_GRAN  = 8
);
    localparam int NUM_WMASKS = DATA_WIDTH / MASK_GRAN;
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout0_valid;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  collision;
    logic                  addr_err;
    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, dout0_valid, dout1, dout1_valid, collision, addr_err
    );
    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, dout0_valid, dout1, dout1_valid, collision, addr_err
    );
endinterface

// File: rtl/sram_1rw1r_pipelined.sv
// sram_1rw1r_pipelined: parametrised 1RW+1R SRAM model with lane masks, 1/2-cycle read latency,
// defined same-address collision policy and out-of-range detection.
module sram_1rw1r_pipelined #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int DEPTH        = 512,
    parameter int MASK_GRAN    = 8,
    parameter int NUM_WMASKS   = DATA_WIDTH / MASK_GRAN,
    parameter int READ_LATENCY = 1,
    parameter bit BYPASS       = 1'b1
) (
    input logic clk,
    input logic rst_n,
    sram_1rw1r_pipelined_if.slave bus
);
    if (DATA_WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("DATA_WIDTH must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
        $error("DEPTH must be within 1..2**ADDR_WIDTH");
    end
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in0, in1, wr0, rd0, rd1, hit;
    logic [DATA_WIDTH-1:0] old0, old1, merged, rd1_data;
    always_comb begin
        in0 = {1'b0, bus.addr0} < DEPTH_W;
        in1 = {1'b0, bus.addr1} < DEPTH_W;
        wr0 = !bus.csb0 && !bus.web0;
        rd0 = !bus.csb0 && bus.web0;
        rd1 = !bus.csb1;
        old0 = in0 ? mem[bus.addr0] : '0;
        old1 = in1 ? mem[bus.addr1] : '0;
        merged = old0;
        for (int i = 0; i < NUM_WMASKS; i++)
            if (bus.wmask0[i]) merged[i*MASK_GRAN +: MASK_GRAN] = bus.din0[i*MASK_GRAN +: MASK_GRAN];
        hit = wr0 && rd1 && in0 && bus.addr0 == bus.addr1;
        rd1_data = (hit && BYPASS) ? merged : old1;
    end
    // The array has no reset; contents survive rst_n.
    always_ff @(posedge clk)
        if (wr0 && in0) mem[bus.addr0] <= merged;
    logic                  s1_v0, s1_v1, s1_hit, s1_err;
    logic [DATA_WIDTH-1:0] s1_d0, s1_d1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_v0  <= 1'b0;
            s1_v1  <= 1'b0;
            s1_hit <= 1'b0;
            s1_err <= 1'b0;
            s1_d0  <= '0;
            s1_d1  <= '0;
        end else begin
            s1_v0  <= rd0;
            s1_v1  <= rd1;
            s1_hit <= hit;
            s1_err <= (!bus.csb0 && !in0) || (rd1 && !in1);
            s1_d0  <= old0;
            s1_d1  <= rd1_data;
        end
    logic                  l_v0, l_v1;
    logic [DATA_WIDTH-1:0] l_d0, l_d1;
    if (READ_LATENCY == 2) begin : g_lat2
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                l_v0 <= 1'b0;
                l_v1 <= 1'b0;
                l_d0 <= '0;
                l_d1 <= '0;
            end else begin
                l_v0 <= s1_v0;
                l_v1 <= s1_v1;
                l_d0 <= s1_d0;
                l_d1 <= s1_d1;
            end
    end else begin : g_lat1
        assign l_v0 = s1_v0;
        assign l_v1 = s1_v1;
        assign l_d0 = s1_d0;
        assign l_d1 = s1_d1;
    end
    // Status flags always leave after one stage; data leaves after READ_LATENCY stages.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.dout0       <= '0;
            bus.dout1       <= '0;
            bus.dout0_valid <= 1'b0;
            bus.dout1_valid <= 1'b0;
            bus.collision   <= 1'b0;
            bus.addr_err    <= 1'b0;
        end else begin
            bus.dout0_valid <= l_v0;
            bus.dout1_valid <= l_v1;
            bus.collision   <= s1_hit;
            bus.addr_err    <= s1_err;
            if (l_v0) bus.dout0 <= l_d0;
            if (l_v1) bus.dout1 <= l_d1;
        end
endmodule

// File: tb/tb_sram_1rw1r_pipelined.sv
// tb_sram_1rw1r_pipelined: directed checks on a default instance (a) and a DEPTH=300, latency-2, old-data instance (b).
module tb_sram_1rw1r_pipelined;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    sram_1rw1r_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .MASK_GRAN(8)) ia ();
    sram_1rw1r_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .MASK_GRAN(8)) ib ();
    sram_1rw1r_pipelined u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    sram_1rw1r_pipelined #(.DEPTH(300), .READ_LATENCY(2), .BYPASS(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic idle();
        ia.csb0 = 1'b1; ia.web0 = 1'b1; ia.wmask0 = '0; ia.addr0 = '0; ia.din0 = '0; ia.csb1 = 1'b1; ia.addr1 = '0;
        ib.csb0 = 1'b1; ib.web0 = 1'b1; ib.wmask0 = '0; ib.addr0 = '0; ib.din0 = '0; ib.csb1 = 1'b1; ib.addr1 = '0;
    endtask
    task automatic p0(input bit sel, input bit wr, input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        if (sel) begin
            ib.csb0 = 1'b0; ib.web0 = !wr; ib.addr0 = a; ib.din0 = d; ib.wmask0 = m;
        end else begin
            ia.csb0 = 1'b0; ia.web0 = !wr; ia.addr0 = a; ia.din0 = d; ia.wmask0 = m;
        end
    endtask
    task automatic p1(input bit sel, input logic [8:0] a);
        if (sel) begin
            ib.csb1 = 1'b0; ib.addr1 = a;
        end else begin
            ia.csb1 = 1'b0; ia.addr1 = a;
        end
    endtask
    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_a_dout0", ia.dout0, 0);
        chk("rst_a_dout1", ia.dout1, 0);
        chk("rst_a_flags", 32'({ia.dout0_valid, ia.dout1_valid, ia.collision, ia.addr_err}), 0);
        chk("rst_b_flags", 32'({ib.dout0_valid, ib.dout1_valid, ib.collision, ib.addr_err}), 0);
        rst_n = 1'b1;
        // full-word write then port-1 read, latency 1
        p0(0, 1, 5, 32'hDEADBEEF, 4'hF);
        tick();
        idle();
        p1(0, 5);
        tick();
        idle();
        chk("t1_early_valid", 32'(ia.dout1_valid), 0);
        tick();
        chk("t1_dout1", ia.dout1, 32'hDEADBEEF);
        chk("t1_valid", 32'(ia.dout1_valid), 1);
        chk("t1_no_coll", 32'(ia.collision), 0);
        tick();
        chk("t1_valid_drop", 32'(ia.dout1_valid), 0);
        chk("t1_hold", ia.dout1, 32'hDEADBEEF);
        // partial mask, then both ports read the same word
        p0(0, 1, 7, 32'h11223344, 4'hF);
        tick();
        p0(0, 1, 7, 32'hAABBCCDD, 4'b0101);
        tick();
        idle();
        p0(0, 0, 7, 0, 0);
        p1(0, 7);
        tick();
        idle();
        chk("t2_wr_no_valid", 32'(ia.dout0_valid), 0);
        tick();
        chk("t2_dout0", ia.dout0, 32'h11BB33DD);
        chk("t2_valid0", 32'(ia.dout0_valid), 1);
        chk("t2_dout1", ia.dout1, 32'h11BB33DD);
        chk("t2_rr_no_coll", 32'(ia.collision), 0);
        // collision: bypass on a, old data on b
        p0(0, 1, 9, 0, 4'hF);
        p0(1, 1, 9, 0, 4'hF);
        tick();
        p0(0, 1, 9, 32'hFFFFFFFF, 4'b0011);
        p0(1, 1, 9, 32'hFFFFFFFF, 4'b0011);
        p1(0, 9);
        p1(1, 9);
        tick();
        idle();
        tick();
        chk("t3_a_coll", 32'(ia.collision), 1);
        chk("t3_a_dout1", ia.dout1, 32'h0000FFFF);
        chk("t3_a_valid1", 32'(ia.dout1_valid), 1);
        chk("t3_b_coll", 32'(ib.collision), 1);
        chk("t3_b_early_valid", 32'(ib.dout1_valid), 0);
        tick();
        chk("t3_a_coll_drop", 32'(ia.collision), 0);
        chk("t3_b_coll_drop", 32'(ib.collision), 0);
        chk("t3_b_dout1", ib.dout1, 32'h00000000);
        chk("t3_b_valid1", 32'(ib.dout1_valid), 1);
        p0(0, 0, 9, 0, 0);
        p0(1, 0, 9, 0, 0);
        tick();
        idle();
        tick();
        chk("t3_a_committed", ia.dout0, 32'h0000FFFF);
        tick();
        chk("t3_b_committed", ib.dout0, 32'h0000FFFF);
        // latency-2 streaming on b
        for (int i = 0; i < 4; i++) begin
            idle();
            p0(1, 1, 9'(i), 32'hA0 + 32'(i), 4'hF);
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i < 4) p1(1, 9'(i));
            tick();
            if (i >= 2 && i < 6) begin
                chk("t4_stream_data", ib.dout1, 32'hA0 + 32'(i - 2));
                chk("t4_stream_valid", 32'(ib.dout1_valid), 1);
            end else
                chk("t4_stream_idle", 32'(ib.dout1_valid), 0);
        end
        // out-of-range accesses on b (DEPTH 300)
        idle();
        p0(1, 1, 299, 32'hCAFEF00D, 4'hF);
        tick();
        idle();
        p0(1, 1, 400, 32'h12345678, 4'hF);
        tick();
        idle();
        p0(1, 0, 299, 0, 0);
        tick();
        chk("t5_err_wr", 32'(ib.addr_err), 1);
        idle();
        p0(1, 0, 400, 0, 0);
        tick();
        idle();
        chk("t5_err_inrange", 32'(ib.addr_err), 0);
        tick();
        chk("t5_dout0_299", ib.dout0, 32'hCAFEF00D);
        chk("t5_err_rd", 32'(ib.addr_err), 1);
        tick();
        chk("t5_dout0_oor", ib.dout0, 0);
        chk("t5_valid_oor", 32'(ib.dout0_valid), 1);
        chk("t5_err_drop", 32'(ib.addr_err), 0);
        p0(1, 0, 400, 0, 0);
        p1(1, 500);
        tick();
        idle();
        tick();
        chk("t5_err_both", 32'(ib.addr_err), 1);
        tick();
        chk("t5_err_single", 32'(ib.addr_err), 0);
        chk("t5_dout1_oor", ib.dout1, 0);
        chk("t5_valid1_oor", 32'(ib.dout1_valid), 1);
        // reset with a latency-2 read in flight
        p1(1, 3);
        tick();
        idle();
        tick();
        tick();
        chk("t6_pre_dout1", ib.dout1, 32'hA3);
        p1(1, 2);
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_b_dout1_rst", ib.dout1, 0);
        chk("t6_a_dout1_rst", ia.dout1, 0);
        chk("t6_b_dout0_rst", ib.dout0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_valid_a", 32'(ib.dout1_valid), 0);
        tick();
        chk("t6_no_valid_b", 32'(ib.dout1_valid), 0);
        chk("t6_dout1_zero", ib.dout1, 0);
        p1(1, 1);
        p0(1, 0, 299, 0, 0);
        tick();
        idle();
        tick();
        tick();
        chk("t6_after_dout1", ib.dout1, 32'hA1);
        chk("t6_after_valid1", 32'(ib.dout1_valid), 1);
        chk("t6_mem_survives", ib.dout0, 32'hCAFEF00D);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
